// File: rtl/neander_pkg.sv
// Shared definitions for the Neander multi-mode register.
// Holds the operation encoding and its select width.
package neander_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_ROR  = 3'b111
    } regn_op_e;

endpackage

// File: rtl/regn_next.sv
// Combinational next-value / carry logic for regn_mode.
// Ports: sq_i/sco_i current state, eop_i op, ed_i load data, esin_i serial in;
//        nq_o next value, nco_o next carry, novf_evt_o overflow/saturation event.
// Macro REGN_SAT_EN: INC at all-ones and DEC at zero hold the value instead of wrapping.
module regn_next
    import neander_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sq_i,
    input  logic             sco_i,
    input  logic [OP_W-1:0]  eop_i,
    input  logic [WIDTH-1:0] ed_i,
    input  logic             esin_i,
    output logic [WIDTH-1:0] nq_o,
    output logic             nco_o,
    output logic             novf_evt_o
);

    regn_op_e op;
    assign op = regn_op_e'(eop_i);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        nq_o       = sq_i;
        nco_o      = sco_i;
        novf_evt_o = 1'b0;
        unique case (op)
            OP_HOLD: begin
            end
            OP_LOAD: begin
                nq_o  = ed_i;
                nco_o = 1'b0;
            end
            OP_INC: begin
                // The extra top bit of the sum is the wrap carry.
                {nco_o, nq_o} = {1'b0, sq_i} + ONE;
`ifdef REGN_SAT_EN
                if (nco_o) nq_o = sq_i;
`endif
                novf_evt_o = nco_o;
            end
            OP_DEC: begin
                // Top bit goes high only when borrowing from zero.
                {nco_o, nq_o} = {1'b0, sq_i} - ONE;
`ifdef REGN_SAT_EN
                if (nco_o) nq_o = sq_i;
`endif
                novf_evt_o = nco_o;
            end
            OP_SHL: begin
                nq_o  = {sq_i[WIDTH-2:0], esin_i};
                nco_o = sq_i[WIDTH-1];
            end
            OP_SHR: begin
                nq_o  = {esin_i, sq_i[WIDTH-1:1]};
                nco_o = sq_i[0];
            end
            OP_ROL: begin
                nq_o  = {sq_i[WIDTH-2:0], sq_i[WIDTH-1]};
                nco_o = sq_i[WIDTH-1];
            end
            OP_ROR: begin
                nq_o  = {sq_i[0], sq_i[WIDTH-1:1]};
                nco_o = sq_i[0];
            end
        endcase
    end

endmodule

// File: rtl/regn_mode.sv
// Parametrised multi-mode register (AC/PC/RDM/REM class) for the Neander datapath.
// Ports: ck clock, ereset async active-low reset, eset sync set, eena enable,
//        eop op select, ed load data, esin serial in, eclr_ovf sticky clear;
//        sq value, sco carry, sovf sticky overflow, sz zero, sn sign.
// Macro REGN_SAT_EN (in regn_next): saturating INC/DEC.
module regn_mode
    import neander_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             ck,
    input  logic             ereset,
    input  logic             eset,
    input  logic             eena,
    input  logic [OP_W-1:0]  eop,
    input  logic [WIDTH-1:0] ed,
    input  logic             esin,
    input  logic             eclr_ovf,
    output logic [WIDTH-1:0] sq,
    output logic             sco,
    output logic             sovf,
    output logic             sz,
    output logic             sn
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] nq;
    logic             nco;
    logic             novf_evt;

    regn_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .sq_i      (q_q),
        .sco_i     (co_q),
        .eop_i     (eop),
        .ed_i      (ed),
        .esin_i    (esin),
        .nq_o      (nq),
        .nco_o     (nco),
        .novf_evt_o(novf_evt)
    );

    always_comb begin
        q_d   = q_q;
        co_d  = co_q;
        ovf_d = ovf_q;
        if (eclr_ovf) ovf_d = 1'b0;
        if (eset) begin
            q_d  = SET_VAL;
            co_d = 1'b0;
        end else if (eena) begin
            q_d  = nq;
            co_d = nco;
            // Placed after the clear so a coincident event wins.
            if (novf_evt) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge ereset) begin
        if (!ereset) begin
            q_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign sq   = q_q;
    assign sco  = co_q;
    assign sovf = ovf_q;
    assign sz   = (q_q == '0);
    assign sn   = q_q[WIDTH-1];

endmodule

// File: tb/tb_regn_mode.sv
// Scoreboard bench for regn_mode (WIDTH=8, SET_VAL=8'hFF).
// Define REGN_SAT_EN for both bench and RTL to exercise saturation.
module tb_regn_mode;

    logic       ck = 1'b0;
    logic       ereset = 1'b0;
    logic       eset = 1'b0;
    logic       eena = 1'b0;
    logic [2:0] eop = 3'b000;
    logic [7:0] ed = 8'h00;
    logic       esin = 1'b0;
    logic       eclr_ovf = 1'b0;
    logic [7:0] sq;
    logic       sco, sovf, sz, sn;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       co;
        logic       ovf;
        logic       z;
        logic       n;
    } exp_t;

    exp_t sbq[$];

    int m_q = 0;
    int m_co = 0;
    int m_ovf = 0;

    regn_mode #(
        .WIDTH  (8),
        .SET_VAL(8'hFF)
    ) dut (
        .ck      (ck),
        .ereset  (ereset),
        .eset    (eset),
        .eena    (eena),
        .eop     (eop),
        .ed      (ed),
        .esin    (esin),
        .eclr_ovf(eclr_ovf),
        .sq      (sq),
        .sco     (sco),
        .sovf    (sovf),
        .sz      (sz),
        .sn      (sn)
    );

    always #5 ck = ~ck;

    task automatic dchk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: register as an integer in 0..255.
    task automatic model(input int s, e, op, d, si, c);
        int ov;
        ov = 0;
        if (c != 0) m_ovf = 0;
        if (s != 0) begin
            m_q  = 255;
            m_co = 0;
        end else if (e != 0) begin
            case (op)
                0: ;
                1: begin m_q = d; m_co = 0; end
                2: begin
                    if (m_q == 255) begin
`ifdef REGN_SAT_EN
                        m_q = 255;
`else
                        m_q = 0;
`endif
                        m_co = 1; ov = 1;
                    end else begin
                        m_q = m_q + 1; m_co = 0;
                    end
                end
                3: begin
                    if (m_q == 0) begin
`ifdef REGN_SAT_EN
                        m_q = 0;
`else
                        m_q = 255;
`endif
                        m_co = 1; ov = 1;
                    end else begin
                        m_q = m_q - 1; m_co = 0;
                    end
                end
                4: begin m_co = m_q / 128; m_q = (m_q * 2 + si) % 256; end
                5: begin m_co = m_q % 2; m_q = m_q / 2 + si * 128; end
                6: begin m_co = m_q / 128; m_q = (m_q * 2) % 256 + m_co; end
                default: begin m_co = m_q % 2; m_q = m_q / 2 + m_co * 128; end
            endcase
            if (ov != 0) m_ovf = 1;
        end
    endtask

    task automatic step(input int s, e, op, d, si, c);
        exp_t x;
        @(negedge ck);
        eset = s[0]; eena = e[0]; eop = op[2:0];
        ed = d[7:0]; esin = si[0]; eclr_ovf = c[0];
        model(s, e, op, d, si, c);
        x.q = m_q[7:0];
        x.co = m_co[0];
        x.ovf = m_ovf[0];
        x.z = (m_q == 0);
        x.n = (m_q >= 128);
        sbq.push_back(x);
    endtask

    task automatic after_edge();
        @(posedge ck);
        #3;
    endtask

    // Monitor: one expected entry per edge, compared 2 units after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge ck);
            #2;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                checks++;
                if ({sq, sco, sovf, sz, sn} !== x) begin
                    errors++;
                    $display("FAIL scoreboard: got q=%h co=%b ovf=%b z=%b n=%b expected q=%h co=%b ovf=%b z=%b n=%b",
                             sq, sco, sovf, sz, sn, x.q, x.co, x.ovf, x.z, x.n);
                end
            end
        end
    end

    initial begin
        #2;
        dchk("reset_q", sq, 0);
        dchk("reset_flags", {sco, sovf, sz}, 3'b001);
        @(negedge ck);
        ereset = 1'b1;

        // Mid-cycle async reset with a loaded value.
        step(0, 1, 1, 8'h5A, 0, 0);
        after_edge();
        dchk("pre_reset_q", sq, 8'h5A);
        ereset = 1'b0;
        #1;
        dchk("async_reset", {sq, sco, sovf, sz}, {8'h00, 3'b001});
        m_q = 0; m_co = 0; m_ovf = 0;
        @(negedge ck);
        eena = 1'b0;
        ereset = 1'b1;

        // Load then hold.
        step(0, 1, 1, 8'h80, 0, 0);
        repeat (3) step(0, 0, $urandom_range(0, 7), $urandom_range(0, 255), 0, 0);
        after_edge();
        dchk("hold_q", sq, 8'h80);
        dchk("hold_sn_sz", {sn, sz}, 2'b10);

        // INC wrap / saturation and sticky clear.
        step(0, 1, 1, 8'hFF, 0, 0);
        step(0, 1, 2, 0, 0, 0);
        after_edge();
`ifdef REGN_SAT_EN
        dchk("inc_sat", {sq, sco, sovf}, {8'hFF, 2'b11});
`else
        dchk("inc_wrap", {sq, sco, sovf, sz}, {8'h00, 3'b111});
`endif
        step(0, 0, 0, 0, 0, 1);
        after_edge();
        dchk("clr_ovf", sovf, 0);

        // DEC wrap with coincident clear: set wins.
        step(0, 1, 1, 8'h00, 0, 0);
        step(0, 1, 3, 0, 0, 1);
        after_edge();
`ifdef REGN_SAT_EN
        dchk("dec_sat", {sq, sco, sovf}, {8'h00, 2'b11});
`else
        dchk("dec_wrap", {sq, sco, sovf}, {8'hFF, 2'b11});
`endif

        // Shift / rotate chain.
        step(0, 1, 1, 8'hB1, 0, 0);
        step(0, 1, 4, 0, 0, 1);
        after_edge();
        dchk("shl", {sq, sco}, {8'h62, 1'b1});
        step(0, 1, 7, 0, 0, 0);
        after_edge();
        dchk("ror", {sq, sco}, {8'h31, 1'b0});
        step(0, 1, 5, 0, 1, 0);
        after_edge();
        dchk("shr", {sq, sco}, {8'h98, 1'b1});

        // eset priority over an enabled INC.
        step(0, 1, 1, 8'h10, 0, 0);
        step(1, 1, 2, 0, 0, 0);
        after_edge();
        dchk("eset_prio", {sq, sco}, {8'hFF, 1'b0});

        // Random traffic, biased toward the wrap corners.
        for (int i = 0; i < 400; i++) begin
            int d;
            d = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 255 : 0;
            step(($urandom_range(0, 15) == 0) ? 1 : 0,
                 ($urandom_range(0, 7) != 0) ? 1 : 0,
                 $urandom_range(0, 7), d,
                 $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        @(negedge ck);
        eena = 1'b0; eset = 1'b0; eclr_ovf = 1'b0;
        repeat (3) @(posedge ck);
        #4;
        dchk("queue_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
